// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Fetch/issue controller of the Thumb core. Owns the PC, fetches one 16-bit
//   instruction at a time, hands it to Decode, then either resolves a branch
//   against NZCV or issues a single exec_en strobe for the decoded uop.
//   Load/store uops wait in MEM until the data-memory access completes.
//
// Ports
//   clk          in   1         core clock, all state changes on posedge
//   reset        in   1         async, active-low
//   imem_req     out  1         fetch request (registered)
//   imem_addr    out  PC_WIDTH  fetch address, always equal to pc
//   imem_ack     in   1         fetch complete, imem_data valid this cycle
//   imem_data    in   16        fetched instruction
//   instruction  out  16        instruction register, drives Decode
//   uop          in   5         decoded micro-op
//   branch_cond  in   4         branch condition, 4'b1111 = not a branch
//   num          in   32        sign-extended halfword branch offset
//   flags        in   4         {N,Z,C,V}
//   ex_stall     in   1         execute not ready, hold in EVAL
//   mem_busy     in   1         data-memory access in progress
//   exec_en      out  1         one-cycle execute strobe
//   pc           out  PC_WIDTH  address of the current instruction
//   state_dbg    out  3         current FSM state (debug visibility)
//
// Handshake: imem_req is raised on entry to FETCH and held, together with a
// stable imem_addr, until the cycle imem_ack is sampled high. That edge
// latches imem_data and drops imem_req. imem_ack is ignored in all other
// states; only one instruction is ever in flight.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int                    PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [15:0]         instruction,
  input  logic [4:0]          uop,
  input  logic [3:0]          branch_cond,
  input  logic [31:0]         num,
  input  logic [3:0]          flags,
  input  logic                ex_stall,
  input  logic                mem_busy,
  output logic                exec_en,
  output logic [PC_WIDTH-1:0] pc,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EVAL   = 3'd3,
    S_MEM    = 3'd4
  } state_t;

  localparam logic [4:0]          UOP_NOP   = 5'd0;
  localparam logic [4:0]          UOP_LDR   = 5'd9;
  localparam logic [4:0]          UOP_STR   = 5'd10;
  localparam logic [3:0]          COND_NONE = 4'b1111;
  localparam logic [PC_WIDTH-1:0] C_TWO     = PC_WIDTH'(2);
  localparam logic [PC_WIDTH-1:0] C_FOUR    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] C_PC_RST  = {RESET_PC[PC_WIDTH-1:1], 1'b0};

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_imem_req;
  logic [15:0]         r_instr;
  logic                r_exec_en;

  logic                w_n, w_z, w_c, w_v;
  logic                w_cond_true;
  logic [PC_WIDTH-1:0] w_num_pc;
  logic [PC_WIDTH-1:0] w_pc_seq;
  logic [PC_WIDTH-1:0] w_pc_branch_raw;
  logic [PC_WIDTH-1:0] w_pc_branch;

  assign {w_n, w_z, w_c, w_v} = flags;

  // Branch target = pc + 4 + (offset << 1), wrapping; bit 0 is always cleared.
  assign w_num_pc        = PC_WIDTH'($signed(num));
  assign w_pc_seq        = r_pc + C_TWO;
  assign w_pc_branch_raw = r_pc + C_FOUR + (w_num_pc << 1);
  assign w_pc_branch     = {w_pc_branch_raw[PC_WIDTH-1:1], 1'b0};

  always_comb begin
    w_cond_true = 1'b0;
    case (branch_cond)
      4'd0:    w_cond_true = w_z;                       // EQ
      4'd1:    w_cond_true = !w_z;                      // NE
      4'd2:    w_cond_true = w_c;                       // CS
      4'd3:    w_cond_true = !w_c;                      // CC
      4'd4:    w_cond_true = w_n;                       // MI
      4'd5:    w_cond_true = !w_n;                      // PL
      4'd6:    w_cond_true = w_v;                       // VS
      4'd7:    w_cond_true = !w_v;                      // VC
      4'd8:    w_cond_true = w_c && !w_z;               // HI
      4'd9:    w_cond_true = !w_c || w_z;               // LS
      4'd10:   w_cond_true = (w_n == w_v);              // GE
      4'd11:   w_cond_true = (w_n != w_v);              // LT
      4'd12:   w_cond_true = !w_z && (w_n == w_v);      // GT
      4'd13:   w_cond_true = w_z || (w_n != w_v);       // LE
      4'd14:   w_cond_true = 1'b1;                      // AL
      default: w_cond_true = 1'b0;                      // not a branch
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= C_PC_RST;
      r_imem_req <= 1'b0;
      r_instr    <= 16'h0000;
      r_exec_en  <= 1'b0;
    end else begin
      // exec_en is a strobe: cleared every cycle unless EVAL issues.
      r_exec_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_instr    <= imem_data;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        // Decode settles on the negedge; its outputs are sampled in EVAL.
        S_DECODE: begin
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          if (!ex_stall) begin
            if (branch_cond != COND_NONE) begin
              r_pc       <= w_cond_true ? w_pc_branch : w_pc_seq;
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end else if (uop == UOP_LDR || uop == UOP_STR) begin
              // pc advances only once the memory access has finished.
              r_exec_en <= 1'b1;
              r_state   <= S_MEM;
            end else begin
              r_exec_en  <= (uop != UOP_NOP);
              r_pc       <= w_pc_seq;
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end
          end
        end
        S_MEM: begin
          if (!mem_busy) begin
            r_pc       <= w_pc_seq;
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign exec_en     = r_exec_en;
  assign state_dbg   = r_state;

endmodule
